// File: rtl/digit_filter_pkg.sv
// Shared types and helpers for the digit result filter: FSM states,
// the blank display code and the per-nibble BCD validity test.
package digit_filter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } filt_state_t;

  localparam logic [23:0] BLANK_DEFAULT = 24'hFFFFFF;

  // 0-9 are digits and F is a leading blank; A..E only appear on a misread.
  function automatic logic bcd_sample_ok(input logic [23:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (v[4*i +: 4] inside {[4'hA:4'hE]}) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Frame-end strobe: one cycle on the inactive-to-active transition of vsync.
// After reset an edge only counts once vsync has been seen inactive.
module vsync_edge_det #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_vsync,
  output logic fe
);

  logic act;
  logic act_q;
  logic armed;

  assign act = ACTIVE_LOW ? ~frame_vsync : frame_vsync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      act_q <= act;
      armed <= armed | ~act;
    end
  end

  assign fe = act & ~act_q & armed;

endmodule

// File: rtl/digit_result_filter.sv
// Temporal filter for the per-frame BCD recognition result: a value reaches
// the display only after STABLE_FRAMES identical valid frames; blanks on frame loss.
module digit_result_filter
  import digit_filter_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned TIMEOUT_CYC   = 33_000_000,
  parameter bit          VS_ACTIVE_LOW = 1'b1,
  parameter logic [23:0] BLANK_CODE    = BLANK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_vsync,
  input  logic [23:0] digit_in,
  output logic [23:0] digit_out,
  output logic        digit_upd,
  output logic        locked,
  output logic        timeout,
  output filt_state_t state_dbg
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_PRE  = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    STABLE_N = 4'(STABLE_FRAMES);

  filt_state_t   state;
  filt_state_t   nxt_state;
  logic [23:0]   cand;
  logic [23:0]   nxt_cand;
  logic [3:0]    match_cnt;
  logic [3:0]    nxt_match;
  logic [TW-1:0] tmo_cnt;
  logic          fe;
  logic          sample_ok;
  logic          tmo_hit;
  logic          do_commit;
  logic          do_blank;

  vsync_edge_det #(.ACTIVE_LOW(VS_ACTIVE_LOW)) u_edge (
    .clk         (clk),
    .rst         (rst),
    .frame_vsync (frame_vsync),
    .fe          (fe)
  );

  assign sample_ok = bcd_sample_ok(digit_in);
  // Blanking fires on the edge where tmo_cnt would reach TIMEOUT_CYC; a frame end there wins.
  assign tmo_hit   = ~fe && (tmo_cnt == TMO_PRE);
  assign state_dbg = state;

  always_comb begin
    nxt_state = state;
    nxt_cand  = cand;
    nxt_match = match_cnt;
    do_commit = 1'b0;
    do_blank  = 1'b0;
    if (fe) begin
      if (!sample_ok) begin
        nxt_state = IDLE;
        nxt_match = 4'd0;
      end else if (state == LOCKED && digit_in == digit_out) begin
        nxt_state = LOCKED;
      end else if (state == TRACK && digit_in == cand) begin
        nxt_match = (match_cnt == 4'hF) ? 4'hF : match_cnt + 4'd1;
        if (nxt_match >= STABLE_N) begin
          do_commit = 1'b1;
          nxt_state = LOCKED;
        end
      end else begin
        nxt_cand  = digit_in;
        nxt_match = 4'd1;
        nxt_state = TRACK;
        if (STABLE_FRAMES == 1) begin
          do_commit = 1'b1;
          nxt_state = LOCKED;
        end
      end
    end else if (tmo_hit) begin
      do_blank  = 1'b1;
      nxt_state = IDLE;
      nxt_match = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= BLANK_CODE;
      match_cnt <= 4'd0;
      tmo_cnt   <= '0;
      digit_out <= BLANK_CODE;
      digit_upd <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= nxt_state;
      cand      <= nxt_cand;
      match_cnt <= nxt_match;
      locked    <= (nxt_state == LOCKED);
      digit_upd <= (do_commit && nxt_cand != digit_out) ||
                   (do_blank && digit_out != BLANK_CODE);
      if (do_commit)     digit_out <= nxt_cand;
      else if (do_blank) digit_out <= BLANK_CODE;
      if (fe)            timeout <= 1'b0;
      else if (do_blank) timeout <= 1'b1;
      if (fe)                      tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_digit_result_filter.sv
// Bench for digit_result_filter: two instances (3-frame and 1-frame filters)
// share stimulus; a frame-level reference model runs alongside both.
module tb_digit_result_filter;
  import digit_filter_pkg::*;

  localparam int TMO = 1000;
  localparam logic [23:0] BLANK = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst = 1'b0;
  logic        vsync = 1'b1;
  logic [23:0] din = 24'h0;
  logic [23:0] out3, out1;
  logic        upd3, lock3, tmo3, upd1, lock1, tmo1;
  filt_state_t dbg3, dbg1;
  bit          chk_on = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] exp_q[$];

  digit_result_filter #(.STABLE_FRAMES(3), .TIMEOUT_CYC(TMO), .VS_ACTIVE_LOW(1'b1)) u_dut3 (
    .clk(clk), .rst(rst), .frame_vsync(vsync), .digit_in(din),
    .digit_out(out3), .digit_upd(upd3), .locked(lock3), .timeout(tmo3), .state_dbg(dbg3)
  );

  digit_result_filter #(.STABLE_FRAMES(1), .TIMEOUT_CYC(TMO), .VS_ACTIVE_LOW(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .frame_vsync(vsync), .digit_in(din),
    .digit_out(out1), .digit_upd(upd1), .locked(lock1), .timeout(tmo1), .state_dbg(dbg1)
  );

  // clock / reset
  always #5 if (clk_run) clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit spec_valid(input logic [23:0] v);
    for (int i = 0; i < 6; i++) begin
      int n;
      n = int'((v >> (4 * i)) & 24'hF);
      if (n > 9 && n != 15) return 1'b0;
    end
    return 1'b1;
  endfunction

  // reference model: runs of identical valid frames, cycle count since last frame end
  logic [23:0] m_out[2];
  bit          m_upd[2], m_lock[2], m_tmo[2];
  logic [23:0] run_val[2];
  int          run_len[2];
  int          n_req[2] = '{3, 1};
  int          cyc_since;
  bit          prev_act, armed_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_out[k] = BLANK; m_upd[k] = 0; m_lock[k] = 0; m_tmo[k] = 0;
        run_val[k] = BLANK; run_len[k] = 0;
      end
      cyc_since = 0; prev_act = 0; armed_m = 0;
      exp_q.delete();
    end else begin
      bit vs_act, fe_m;
      vs_act  = (vsync == 1'b0);
      fe_m    = vs_act && !prev_act && armed_m;
      armed_m = armed_m || !vs_act;
      prev_act = vs_act;
      for (int k = 0; k < 2; k++) m_upd[k] = 0;
      if (fe_m) begin
        cyc_since = 0;
        for (int k = 0; k < 2; k++) begin
          m_tmo[k] = 0;
          if (!spec_valid(din)) run_len[k] = 0;
          else if (run_len[k] > 0 && din == run_val[k]) run_len[k]++;
          else begin run_val[k] = din; run_len[k] = 1; end
          if (run_len[k] == n_req[k]) begin
            if (m_out[k] != run_val[k]) begin
              m_upd[k] = 1;
              if (k == 0) exp_q.push_back(run_val[k]);
            end
            m_out[k] = run_val[k];
          end
          m_lock[k] = (run_len[k] >= n_req[k]);
        end
      end else if (cyc_since < TMO) begin
        cyc_since++;
        if (cyc_since == TMO) begin
          for (int k = 0; k < 2; k++) begin
            if (m_out[k] != BLANK) begin
              m_upd[k] = 1;
              if (k == 0) exp_q.push_back(BLANK);
            end
            m_out[k] = BLANK; m_tmo[k] = 1; run_len[k] = 0; m_lock[k] = 0;
          end
        end
      end
    end
  end

  // lockstep scoreboard
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("dut3.digit_out", out3, m_out[0]);
      check("dut3.digit_upd", upd3, m_upd[0]);
      check("dut3.locked",    lock3, m_lock[0]);
      check("dut3.timeout",   tmo3, m_tmo[0]);
      check("dut1.digit_out", out1, m_out[1]);
      check("dut1.digit_upd", upd1, m_upd[1]);
      check("dut1.locked",    lock1, m_lock[1]);
      check("dut1.timeout",   tmo1, m_tmo[1]);
      if (upd3 === 1'b1) begin
        if (exp_q.size() == 0) check("sb.unexpected_upd", 1'b1, 1'b0);
        else check("sb.upd_value", out3, exp_q.pop_front());
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic fe_start(input logic [23:0] d);
    vsync = 1'b0;
    din   = d;
    @(negedge clk);
  endtask

  task automatic fe_end();
    vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame(input logic [23:0] d, input int act_len);
    vsync = 1'b0;
    din   = d;
    repeat (act_len) @(negedge clk);
    fe_end();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    check("rst.digit_out", out3, BLANK);
    check("rst.digit_upd", upd3, 1'b0);
    check("rst.locked",    lock3, 1'b0);
    check("rst.timeout",   tmo3, 1'b0);
    check("rst.state",     24'(dbg3), 24'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [23:0] rand_valid();
    logic [23:0] v;
    for (int i = 0; i < 6; i++) begin
      int r;
      r = $urandom_range(0, 11);
      v[4*i +: 4] = (r < 10) ? 4'(r) : 4'hF;
    end
    return v;
  endfunction

  typedef struct {
    bit          rst_before;
    logic [23:0] d;
    logic [23:0] exp_out;
    bit          exp_upd;
    bit          exp_lock;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{0, 24'hFF1234, BLANK,      0, 0};
    tbl[1]  = '{0, 24'hFF1234, BLANK,      0, 0};
    tbl[2]  = '{0, 24'hFF1234, 24'hFF1234, 1, 1};
    tbl[3]  = '{0, 24'hFF12A4, 24'hFF1234, 0, 0};
    tbl[4]  = '{0, 24'hFF1234, 24'hFF1234, 0, 0};
    tbl[5]  = '{0, 24'hFF1234, 24'hFF1234, 0, 0};
    tbl[6]  = '{0, 24'hFF1234, 24'hFF1234, 0, 1};
    tbl[7]  = '{1, 24'hFF1234, BLANK,      0, 0};
    tbl[8]  = '{0, 24'hFF1234, BLANK,      0, 0};
    tbl[9]  = '{0, 24'hFF1235, BLANK,      0, 0};
    tbl[10] = '{0, 24'hFF1235, BLANK,      0, 0};
    tbl[11] = '{0, 24'hFF1235, 24'hFF1235, 1, 1};

    // reset with no clock running
    #3 rst = 1'b1;
    #1;
    check("por.digit_out", out3, BLANK);
    check("por.digit_upd", upd3, 1'b0);
    check("por.locked",    lock3, 1'b0);
    check("por.timeout",   tmo3, 1'b0);
    check("por.state",     24'(dbg3), 24'(IDLE));
    clk_run = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    idle(4);

    // table-driven frame sequences, sampled 1 clk after each frame end
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst_before) mid_reset();
      fe_start(tbl[i].d);
      check($sformatf("tbl%0d.digit_out", i), out3, tbl[i].exp_out);
      check($sformatf("tbl%0d.digit_upd", i), upd3, tbl[i].exp_upd);
      check($sformatf("tbl%0d.locked", i),    lock3, tbl[i].exp_lock);
      fe_end();
      idle(2);
    end

    // frame loss: blanking exactly TMO clocks after the last frame end
    for (int i = 0; i < 3; i++) begin frame(24'hFF5678, 1); idle(3); end
    frame(24'hFF5678, 1);
    idle(TMO - 2);
    check("tmo.early_timeout", tmo3, 1'b0);
    check("tmo.early_out",     out3, 24'hFF5678);
    idle(1);
    check("tmo.timeout",   tmo3, 1'b1);
    check("tmo.digit_out", out3, BLANK);
    check("tmo.locked",    lock3, 1'b0);
    check("tmo.digit_upd", upd3, 1'b1);
    idle(1);
    check("tmo.upd_once",  upd3, 1'b0);
    check("tmo.held",      tmo3, 1'b1);
    fe_start(24'hFF5678);
    check("tmo.cleared",   tmo3, 1'b0);
    fe_end();
    idle(3);

    // frame end on the cycle the timeout would fire
    frame(24'hFF0001, 1);
    idle(TMO - 2);
    fe_start(24'hFF0002);
    check("race.dut1_out",     out1, 24'hFF0002);
    check("race.dut1_upd",     upd1, 1'b1);
    check("race.dut1_timeout", tmo1, 1'b0);
    check("race.dut3_timeout", tmo3, 1'b0);
    fe_end();
    idle(3);

    // randomized frames against the reference model
    begin
      logic [23:0] d;
      d = rand_valid();
      for (int n = 0; n < 200; n++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 55) d = d;
        else if (r < 75) d = rand_valid();
        else if (r < 90) begin
          d = rand_valid();
          d[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(10, 14));
        end else d = BLANK;
        frame(d, $urandom_range(1, 3));
        if ($urandom_range(0, 39) == 0) idle($urandom_range(TMO - 6, TMO + 6));
        else idle($urandom_range(0, 20));
      end
    end

    idle(4);
    chk_on = 1'b0;
    check("sb.drained", 24'(exp_q.size()), 24'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
